// File: rtl/lif_post_neuron.sv
// Leaky integrate-and-fire postsynaptic neuron driving the STDP post_spike input.
// Weighted pre-spikes are integrated with a shift-based leak; on reaching
// threshold the neuron emits a one-cycle pulse, clears its potential and
// optionally ignores input for a fixed number of enabled cycles.
module lif_post_neuron #(
  parameter int unsigned NUM_PRE        = 4,
  parameter int unsigned W_WIDTH        = 4,
  parameter int unsigned V_WIDTH        = 8,
  parameter int unsigned THRESHOLD      = 16,
  parameter int unsigned LEAK_SHIFT     = 3,
  parameter int unsigned REFRACT_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NUM_PRE-1:0]           pre_spike,
  input  logic [NUM_PRE*W_WIDTH-1:0]   weight,
  output logic                         post_spike,
  output logic [V_WIDTH-1:0]           membrane,
  output logic                         refractory,
  output logic [7:0]                   spike_count
);

  localparam int unsigned S_WIDTH   = W_WIDTH + 2;
  localparam int unsigned SUM_WIDTH = V_WIDTH + 1;
  localparam int unsigned R_WIDTH   = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;
  localparam logic [V_WIDTH-1:0] V_MAX = '1;

  typedef enum logic {
    INTEGRATE = 1'b0,
    REFRACT   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [R_WIDTH-1:0]  rcnt_q, rcnt_d;
  logic [V_WIDTH-1:0]  membrane_d;
  logic                post_spike_d;
  logic                refractory_d;
  logic [7:0]          spike_count_d;

  logic [S_WIDTH-1:0]   syn;
  logic [SUM_WIDTH-1:0] v_sum;
  logic [V_WIDTH-1:0]   v_next;
  logic                 fire;

  // Synaptic drive: sum of weights whose presynaptic neuron spiked (neuron 0 in the top nibble)
  always_comb begin
    syn = '0;
    for (int i = 0; i < int'(NUM_PRE); i++) begin
      if (pre_spike[i]) begin
        syn = syn + S_WIDTH'(weight[(int'(NUM_PRE) - 1 - i) * int'(W_WIDTH) +: W_WIDTH]);
      end
    end
  end

  // Leaky integration with saturation; the leak truncates so small potentials do not decay
  always_comb begin
    v_sum  = SUM_WIDTH'(membrane) - SUM_WIDTH'(membrane >> LEAK_SHIFT) + SUM_WIDTH'(syn);
    v_next = (v_sum > SUM_WIDTH'(V_MAX)) ? V_MAX : v_sum[V_WIDTH-1:0];
    fire   = (v_next >= V_WIDTH'(THRESHOLD));
  end

  // Next-state and next-output decode; with en low everything holds and the pulse drops
  always_comb begin
    state_d       = state_q;
    rcnt_d        = rcnt_q;
    membrane_d    = membrane;
    post_spike_d  = 1'b0;
    spike_count_d = spike_count;

    if (en) begin
      case (state_q)
        INTEGRATE: begin
          if (fire) begin
            post_spike_d  = 1'b1;
            membrane_d    = '0;
            spike_count_d = spike_count + 8'd1;
            if (REFRACT_CYCLES > 0) begin
              rcnt_d  = R_WIDTH'(REFRACT_CYCLES);
              state_d = REFRACT;
            end
          end else begin
            membrane_d = v_next;
          end
        end
        REFRACT: begin
          membrane_d = '0;
          if (rcnt_q == R_WIDTH'(1)) begin
            rcnt_d  = '0;
            state_d = INTEGRATE;
          end else begin
            rcnt_d = rcnt_q - R_WIDTH'(1);
          end
        end
        default: begin
          state_d = INTEGRATE;
          rcnt_d  = '0;
        end
      endcase
    end

    refractory_d = (state_d == REFRACT);
  end

  // State and output registers; synchronous reset wins over enable
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INTEGRATE;
      rcnt_q      <= '0;
      membrane    <= '0;
      post_spike  <= 1'b0;
      refractory  <= 1'b0;
      spike_count <= '0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      membrane    <= membrane_d;
      post_spike  <= post_spike_d;
      refractory  <= refractory_d;
      spike_count <= spike_count_d;
    end
  end

endmodule

// File: tb/tb_lif_post_neuron.sv
// Scoreboard bench for lif_post_neuron: a default instance and a THRESHOLD=255
// instance share stimulus; a cycle-level arithmetic model predicts both.
module tb_lif_post_neuron;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  pre_spike;
  logic [15:0] weight;

  logic        ps_a, refr_a;
  logic [7:0]  mem_a, cnt_a;
  logic        ps_b, refr_b;
  logic [7:0]  mem_b, cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit ps;
    int mem;
    bit refr;
    int cnt;
  } exp_t;

  exp_t exp_q_a[$];
  exp_t exp_q_b[$];

  // Reference model state per instance: potential, remaining blocked cycles, fires, pulse
  int m_v[2];
  int m_r[2];
  int m_cnt[2];
  bit m_ps[2];

  lif_post_neuron dut_a (
    .clk(clk), .rst(rst), .en(en), .pre_spike(pre_spike), .weight(weight),
    .post_spike(ps_a), .membrane(mem_a), .refractory(refr_a), .spike_count(cnt_a)
  );

  lif_post_neuron #(.THRESHOLD(255)) dut_b (
    .clk(clk), .rst(rst), .en(en), .pre_spike(pre_spike), .weight(weight),
    .post_spike(ps_b), .membrane(mem_b), .refractory(refr_b), .spike_count(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input int k, input int thr, input bit r, input bit e,
                            input logic [3:0] ps, input logic [15:0] w);
    int syn;
    int nv;
    if (r) begin
      m_v[k] = 0; m_r[k] = 0; m_cnt[k] = 0; m_ps[k] = 0;
    end else if (!e) begin
      m_ps[k] = 0;
    end else if (m_r[k] > 0) begin
      m_ps[k] = 0;
      m_v[k]  = 0;
      m_r[k]  = m_r[k] - 1;
    end else begin
      syn = 0;
      for (int i = 0; i < 4; i++)
        if (ps[i]) syn += int'((w >> (12 - 4 * i)) & 16'hF);
      nv = m_v[k] - m_v[k] / 8 + syn;
      if (nv > 255) nv = 255;
      if (nv >= thr) begin
        m_ps[k]  = 1;
        m_v[k]   = 0;
        m_cnt[k] = (m_cnt[k] + 1) % 256;
        m_r[k]   = 4;
      end else begin
        m_ps[k] = 0;
        m_v[k]  = nv;
      end
    end
  endtask

  // One clock: drive at negedge, predict, queue expectations, return 2 time units after the edge
  task automatic cyc(input bit r, input bit e, input logic [3:0] ps, input logic [15:0] w);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; pre_spike = ps; weight = w;
    model_step(0, 16, r, e, ps, w);
    model_step(1, 255, r, e, ps, w);
    x.ps = m_ps[0]; x.mem = m_v[0]; x.refr = (m_r[0] > 0); x.cnt = m_cnt[0];
    exp_q_a.push_back(x);
    x.ps = m_ps[1]; x.mem = m_v[1]; x.refr = (m_r[1] > 0); x.cnt = m_cnt[1];
    exp_q_b.push_back(x);
    @(posedge clk);
    #2;
  endtask

  // Monitor: after every active edge pop the prediction and compare all outputs
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (exp_q_a.size() > 0) begin
      x = exp_q_a.pop_front();
      check("a.post_spike", int'(ps_a), int'(x.ps));
      check("a.membrane", int'(mem_a), x.mem);
      check("a.refractory", int'(refr_a), int'(x.refr));
      check("a.spike_count", int'(cnt_a), x.cnt);
    end
    if (exp_q_b.size() > 0) begin
      x = exp_q_b.pop_front();
      check("b.post_spike", int'(ps_b), int'(x.ps));
      check("b.membrane", int'(mem_b), x.mem);
      check("b.refractory", int'(refr_b), int'(x.refr));
      check("b.spike_count", int'(cnt_b), x.cnt);
    end
  end

  initial begin
    int fires;
    rst = 1'b1; en = 1'b0; pre_spike = '0; weight = 16'h4321;
    m_v = '{0, 0}; m_r = '{0, 0}; m_cnt = '{0, 0}; m_ps = '{0, 0};

    // Reset with all inputs active
    cyc(1, 1, 4'hF, 16'h4321);
    cyc(1, 1, 4'hF, 16'h4321);
    check("rst.post_spike", int'(ps_a), 0);
    check("rst.membrane", int'(mem_a), 0);
    check("rst.refractory", int'(refr_a), 0);
    check("rst.spike_count", int'(cnt_a), 0);

    // Single input, no leak below 8
    cyc(0, 1, 4'b0001, 16'h4321);
    check("single.membrane", int'(mem_a), 4);
    for (int i = 0; i < 4; i++) cyc(0, 1, 4'b0000, 16'h4321);
    check("single.hold", int'(mem_a), 4);

    // Periodic firing with refractory
    cyc(1, 1, 4'h0, 16'h4321);
    fires = 0;
    for (int i = 0; i < 18; i++) begin
      cyc(0, 1, 4'hF, 16'h4321);
      if (i == 0) check("periodic.first", int'(mem_a), 10);
      if (i == 1) check("periodic.fire", int'(ps_a), 1);
      if (i == 2) check("periodic.refr", int'(refr_a), 1);
      if (i == 6) check("periodic.restart", int'(mem_a), 10);
      if (ps_a) fires++;
    end
    check("periodic.count", int'(cnt_a), 3);
    check("periodic.pulses", fires, 3);

    // Saturation on the THRESHOLD=255 instance
    cyc(1, 1, 4'h0, 16'hFFFF);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 4'hF, 16'hFFFF);
      if (i == 4) check("sat.235", int'(mem_b), 235);
    end
    check("sat.fire", int'(ps_b), 1);
    check("sat.clear", int'(mem_b), 0);

    // Enable gating holds state and drops input
    cyc(1, 1, 4'h0, 16'h4321);
    cyc(0, 1, 4'hF, 16'h4321);
    for (int i = 0; i < 5; i++) cyc(0, 0, 4'hF, 16'h4321);
    check("gate.hold", int'(mem_a), 10);
    cyc(0, 1, 4'hF, 16'h4321);
    check("gate.fire", int'(ps_a), 1);

    // Reset in the middle of refractory
    cyc(0, 1, 4'hF, 16'h4321);
    cyc(1, 1, 4'hF, 16'h4321);
    check("midrst.refr", int'(refr_a), 0);
    check("midrst.count", int'(cnt_a), 0);
    cyc(0, 1, 4'hF, 16'h4321);
    check("midrst.mem", int'(mem_a), 10);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, e;
      logic [15:0] w;
      r = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 9) < 8);
      w = ($urandom_range(0, 1) == 0) ? 16'h4321 : 16'($urandom);
      cyc(r, e, 4'($urandom), w);
    end

    check("queue.drained", exp_q_a.size() + exp_q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
